mul_16b_seq: RTL and testbench

MUL_16B_SEQ -- requirements
Module: mul_16b_seq

---
 rtl/mul_16b_seq.sv | 106 ++++++++++
 tb/tb_mul_16b_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mul_16b_seq.sv
// Sequential 16x16 shift-add multiplier, signed or unsigned, with a valid/ready handshake.
// Takes one step per cycle, so the latency is a fixed 16 CALC cycles plus a DONE hold.
module adder_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carryin,
    output logic [15:0] sum,
    output logic        carryout
);
    assign {carryout, sum} = {1'b0, a} + {1'b0, b} + {16'h0000, carryin};
endmodule

module mul_16b_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    input  logic        signed_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] mcand;
    logic [31:0] acc;
    logic [31:0] acc_nxt;
    logic [3:0]  cnt;
    logic        neg;
    logic [15:0] add_sum;
    logic        add_cout;
    logic [15:0] mag1;
    logic [15:0] mag2;
    logic        accept;

    // 0x8000 negates to itself, which is the correct unsigned magnitude
    assign mag1 = (signed_op && src1[15]) ? (~src1 + 16'd1) : src1;
    assign mag2 = (signed_op && src2[15]) ? (~src2 + 16'd1) : src2;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    adder_16b u_add (
        .a        (acc[31:16]),
        .b        (mcand),
        .carryin  (1'b0),
        .sum      (add_sum),
        .carryout (add_cout)
    );

    always_comb begin
        acc_nxt = {1'b0, acc[31:16], acc[15:1]};
        if (acc[0]) begin
            acc_nxt = {add_cout, add_sum, acc[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (cnt == 4'd15) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mcand <= 16'h0000;
            acc   <= 32'h0;
            cnt   <= 4'd0;
            neg   <= 1'b0;
            res   <= 32'h0;
        end else begin
            if (accept) begin
                mcand <= mag1;
                acc   <= {16'h0000, mag2};
                cnt   <= 4'd0;
                neg   <= signed_op && (src1[15] ^ src2[15]);
            end else if (state == CALC) begin
                acc <= acc_nxt;
                cnt <= cnt + 4'd1;
                // the final step's sum goes straight into res as DONE is entered
                if (cnt == 4'd15) begin
                    res <= neg ? (~acc_nxt + 32'd1) : acc_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_16b_seq.sv
// Directed and randomized checks of mul_16b_seq against an arithmetic product model.
// Covers latency, backpressure, mid-operation reset and operand changes during CALC.
module tb_mul_16b_seq;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] src1;
    logic [15:0] src2;
    logic        signed_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    mul_16b_seq dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .signed_op (signed_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
        longint pa;
        longint pb;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'({48'h0, a});
            pb = longint'({48'h0, b});
        end
        return 32'(pa * pb);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input bit scramble, input int hold);
        logic [31:0] exp;
        exp = model(a, b, s);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        src1 = a;
        src2 = b;
        signed_op = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("busy_calc", {31'b0, busy}, 32'd1);
        for (int k = 1; k < 16; k++) begin
            if (scramble) begin
                src1 = 16'($urandom);
                src2 = 16'($urandom);
                signed_op = 1'($urandom);
                in_valid = 1'($urandom);
            end
            tick();
        end
        chk("out_valid_early", {31'b0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("out_valid_lat", {31'b0, out_valid}, 32'd1);
        chk("res", res, exp);
        chk("in_ready_done", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            tick();
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_res", res, exp);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_valid", {31'b0, out_valid}, 32'd0);
        chk("post_in_ready", {31'b0, in_ready}, 32'd1);
        chk("post_busy", {31'b0, busy}, 32'd0);
        chk("post_res_held", res, exp);
    endtask

    task automatic chk_reset_state();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_res", res, 32'h0);
    endtask

    initial begin
        resetn = 1'b0;
        in_valid = 1'b0;
        src1 = 16'h0;
        src2 = 16'h0;
        signed_op = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk_reset_state();
        resetn = 1'b1;
        tick();

        run_op(16'd3, 16'd5, 1'b0, 1'b0, 0);
        chk("req028_res", res, 32'h0000000F);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0);
        chk("req029_res", res, 32'hFFFE0001);
        run_op(16'hFFFD, 16'd7, 1'b1, 1'b0, 0);
        chk("req030_a", res, 32'hFFFFFFEB);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        chk("req030_b", res, 32'h00000001);
        run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0);
        chk("req030_c", res, 32'h40000000);
        run_op(16'h0000, 16'hFFFF, 1'b1, 1'b0, 0);
        chk("zero_neg", res, 32'h0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0);
        run_op(16'h1234, 16'hABCD, 1'b0, 1'b0, 10);
        run_op(16'd10, 16'd10, 1'b0, 1'b1, 0);
        chk("req033_res", res, 32'h00000064);

        // abort at CALC step 8, with reset held across several cycles
        src1 = 16'h1234;
        src2 = 16'h5678;
        signed_op = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        resetn = 1'b0;
        tick();
        chk_reset_state();
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rst_no_valid", {31'b0, out_valid}, 32'd0);
        end
        resetn = 1'b1;
        run_op(16'd2, 16'd2, 1'b0, 1'b0, 0);
        chk("req032_res", res, 32'h00000004);

        for (int n = 0; n < 40; n++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
